// File: rtl/jp_multi_if.sv
// CPU-side register bus for jp_multi: write strobe, address, write data and read data.
interface jp_multi_if;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  din;
    logic [7:0]  dout;

    modport master (output wr, output addr, output din, input dout);
    modport slave  (input wr, input addr, input din, output dout);
endinterface

// File: rtl/jp_multi.sv
// Multi-pad serial joypad scanner with NES-style strobe/shift CPU read registers.
module jp_multi #(
    parameter int unsigned NUM_PADS    = 2,
    parameter int unsigned NUM_BITS    = 8,
    parameter int unsigned CLK_DIV     = 16,
    parameter int unsigned IDLE_CYCLES = 256,
    parameter logic [15:0] BASE_ADDR   = 16'h4016
) (
    input  logic                clk,
    input  logic                rst,
    jp_multi_if.slave           bus,
    input  logic [NUM_PADS-1:0] jp_data,
    output logic                jp_clk,
    output logic                jp_latch,
    output logic                scan_done
);

    // One counter serves both the idle wait and the per-phase divider.
    localparam int unsigned CNT_MAX = (IDLE_CYCLES > CLK_DIV) ? IDLE_CYCLES : CLK_DIV;
    localparam int unsigned CW      = $clog2(CNT_MAX);
    localparam int unsigned IW      = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam logic [15:0] ADDR1   = BASE_ADDR + 16'd1;

    typedef enum logic [1:0] {StIdle, StLatch, StLow, StHigh} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          phase_last, idle_last, bit_last, sample;

    logic [NUM_BITS-1:0] shadow_q [NUM_PADS];
    logic [NUM_BITS-1:0] shadow_d [NUM_PADS];
    logic [NUM_BITS-1:0] pad_q    [NUM_PADS];
    logic [NUM_BITS-1:0] rd_q     [NUM_PADS];
    logic [NUM_PADS-1:0] shift;
    logic                strobe_q;
    logic [15:0]         prev_addr_q;
    logic                odd_addr, rd_hit;
    logic [3:0]          lsb;
    logic                unused_din;

    assign phase_last = (cnt_q == CW'(CLK_DIV - 1));
    assign idle_last  = (cnt_q == CW'(IDLE_CYCLES - 1));
    assign bit_last   = (idx_q == IW'(NUM_BITS - 1));

    // Scanner state register; jp_clk/jp_latch are registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            idx_q    <= '0;
            jp_clk   <= 1'b0;
            jp_latch <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            jp_clk   <= (state_d == StHigh);
            jp_latch <= (state_d == StLatch);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: if (idle_last) begin
                state_d = StLatch;
                cnt_d   = '0;
                idx_d   = '0;
            end
            StLatch: if (phase_last) begin
                state_d = StLow;
                cnt_d   = '0;
            end
            StLow: if (phase_last) begin
                state_d = bit_last ? StIdle : StHigh;
                cnt_d   = '0;
            end
            StHigh: if (phase_last) begin
                state_d = StLow;
                cnt_d   = '0;
                idx_d   = idx_q + IW'(1);
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        sample    = (state_q == StLow) && phase_last;
        scan_done = sample && bit_last;
    end

    // Final sample and commit share a cycle, so commit takes the merged shadow word.
    always_comb begin
        for (int p = 0; p < NUM_PADS; p++) begin
            shadow_d[p] = shadow_q[p];
            if (sample) shadow_d[p][idx_q] = ~jp_data[p];
        end
    end

    assign odd_addr = (bus.addr == ADDR1);
    assign rd_hit   = !bus.wr && ((bus.addr == BASE_ADDR) || odd_addr) &&
                      (bus.addr != prev_addr_q);

    always_comb begin
        for (int p = 0; p < NUM_PADS; p++) begin
            shift[p] = rd_hit && (((p % 2) == 1) == odd_addr);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strobe_q    <= 1'b0;
            prev_addr_q <= 16'h0000;
            for (int p = 0; p < NUM_PADS; p++) begin
                shadow_q[p] <= '0;
                pad_q[p]    <= '0;
                rd_q[p]     <= '0;
            end
        end else begin
            prev_addr_q <= bus.addr;
            if (bus.wr && (bus.addr == BASE_ADDR)) strobe_q <= bus.din[0];
            for (int p = 0; p < NUM_PADS; p++) begin
                shadow_q[p] <= shadow_d[p];
                if (scan_done) pad_q[p] <= shadow_d[p];
                if (strobe_q) rd_q[p] <= pad_q[p];
                else if (shift[p]) rd_q[p] <= {1'b1, rd_q[p][NUM_BITS-1:1]};
            end
        end
    end

    for (genvar p = 0; p < 4; p++) begin : g_lsb
        if (p < NUM_PADS) begin : g_pad
            assign lsb[p] = rd_q[p][0];
        end else begin : g_none
            assign lsb[p] = 1'b0;
        end
    end

    assign bus.dout = (bus.addr == BASE_ADDR) ? {6'b0, lsb[2], lsb[0]} :
                      odd_addr                ? {6'b0, lsb[3], lsb[1]} : 8'h00;

    assign unused_din = ^bus.din[7:1];

endmodule
